// File: rtl/psc_trigger_rx.sv
// psc_trigger_rx: oversampling receiver for the PSC trigger serial link.
// Validates start/stop framing and pulses trigger_out when the byte matches TRIG_CODE.
module psc_trigger_rx #(
  parameter int          CLK_DIV   = 10,
  parameter logic [7:0]  TRIG_CODE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psc_input,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       trigger_out,
  output logic       frame_error,
  output logic       busy
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state_q;
  logic [2:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data_q;
  logic          stop_hit_q;
  logic          stop_bit_q;
  logic          rx_valid_q;
  logic          trigger_q;
  logic          frame_error_q;
  logic          line;
  logic          fall;
  logic          tick;

  assign line        = sync_q[1];
  assign fall        = ~sync_q[1] & sync_q[2];
  assign tick        = cnt_q == '0;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign trigger_out = trigger_q;
  assign frame_error = frame_error_q;
  assign busy        = state_q != IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      sync_q        <= 3'b111;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      stop_hit_q    <= 1'b0;
      stop_bit_q    <= 1'b1;
      rx_valid_q    <= 1'b0;
      trigger_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[1:0], psc_input};
      rx_valid_q    <= 1'b0;
      trigger_q     <= 1'b0;
      frame_error_q <= 1'b0;
      cnt_q         <= tick ? cnt_q : cnt_q - CW'(1);
      case (state_q)
        IDLE: if (fall) begin
          state_q <= START;
          cnt_q   <= HALF;
        end
        START: if (tick) begin
          state_q <= line ? IDLE : DATA;
          idx_q   <= '0;
          cnt_q   <= FULL;
        end
        DATA: if (tick) begin
          shift_q[idx_q] <= line;
          idx_q          <= idx_q + 3'd1;
          cnt_q          <= FULL;
          if (idx_q == 3'd7) state_q <= STOP;
        end
        // The stop sample is registered first; outputs and the exit follow one cycle later.
        STOP: if (stop_hit_q) begin
          stop_hit_q <= 1'b0;
          if (stop_bit_q) begin
            rx_data_q  <= shift_q;
            rx_valid_q <= 1'b1;
            trigger_q  <= shift_q == TRIG_CODE;
            state_q    <= IDLE;
          end else begin
            frame_error_q <= 1'b1;
            state_q       <= BREAK;
          end
        end else if (tick) begin
          stop_hit_q <= 1'b1;
          stop_bit_q <= line;
        end
        BREAK: if (line) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psc_trigger_rx.sv
// tb_psc_trigger_rx: randomized frames against a frame-level model with a queued scoreboard.
module tb_psc_trigger_rx;
  localparam int         CLK_DIV = 10;
  localparam logic [7:0] TRIG    = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       psc_input = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, trigger_out, frame_error, busy;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       trig;
    logic       ferr;
  } exp_t;

  exp_t       q[$];
  int         trig_log[$];
  exp_t       m_e;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_data = 8'h00;

  psc_trigger_rx #(.CLK_DIV(CLK_DIV), .TRIG_CODE(TRIG)) dut (
    .clk(clk), .reset(reset), .psc_input(psc_input), .rx_data(rx_data),
    .rx_valid(rx_valid), .trigger_out(trigger_out), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected finish", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && (rx_valid || frame_error || trigger_out)) begin
      if (trigger_out) trig_log.push_back(cyc);
      if (q.size() == 0) chk("unexpected_pulse", {29'b0, rx_valid, frame_error, trigger_out}, 32'd0);
      else begin
        m_e = q.pop_front();
        chk("pulse_cycle", cyc, m_e.cyc);
        chk("rx_valid", 32'(rx_valid), 32'(!m_e.ferr));
        chk("frame_error", 32'(frame_error), 32'(m_e.ferr));
        chk("trigger_out", 32'(trigger_out), 32'(m_e.trig));
        chk("rx_data", 32'(rx_data), 32'(m_e.data));
        chk("busy_at_pulse", 32'(busy), 32'(m_e.ferr));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a negedge, so the first sync flop sees the start bit at edge cyc+1.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic push, input int low_hold);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop, b, 1'b0};
    if (push) begin
      e.cyc  = cyc + 1 + 2 + CLK_DIV / 2 + 9 * CLK_DIV + 1;
      e.ferr = !stop;
      e.trig = stop && (b == TRIG);
      e.data = stop ? b : last_data;
      if (stop) last_data = b;
      q.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      psc_input = bits[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    if (!stop) begin
      repeat (low_hold) @(negedge clk);
      psc_input = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_trigger_out"}, 32'(trigger_out), 32'd0);
    chk({tag, "_frame_error"}, 32'(frame_error), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int e_cyc;
    logic [7:0] b;
    logic       good;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;
    idle(5);

    send_frame(TRIG, 1'b1, 1'b1, 0);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b1, 0);
    idle(20);

    // Three-cycle low glitch: start must be rejected at the half-bit sample.
    psc_input = 1'b0;
    e_cyc = cyc + 1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) psc_input = 1'b1;
      @(negedge clk);
      chk("glitch_busy", 32'(busy), 32'(cyc >= e_cyc + 2 && cyc < e_cyc + 7));
    end
    idle(10);

    send_frame(TRIG, 1'b0, 1'b1, 190);
    idle(10);
    send_frame(TRIG, 1'b1, 1'b1, 0);
    idle(20);
    drain();

    trig_log.delete();
    send_frame(TRIG, 1'b1, 1'b1, 0);
    send_frame(TRIG, 1'b1, 1'b1, 0);
    idle(10);
    drain();
    chk("b2b_spacing", (trig_log.size() == 2) ? 32'(trig_log[1] - trig_log[0]) : 32'hFFFF_FFFF, 32'd100);
    idle(20);

    // Reset at data bit 4, released at data bit 6; bits 6, 7 and stop are high.
    fork
      send_frame({2'b11, 6'($urandom)}, 1'b1, 1'b0, 0);
      begin
        repeat (5 * CLK_DIV) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_vals("abort");
        repeat (20) @(negedge clk);
        reset = 1'b1;
      end
    join
    last_data = 8'h00;
    idle(10);
    chk("abort_rx_data_after", 32'(rx_data), 32'd0);
    chk("abort_busy_after", 32'(busy), 32'd0);
    send_frame(8'($urandom), 1'b1, 1'b1, 0);
    idle(10);
    drain();

    for (int n = 0; n < 24; n++) begin
      b    = ($urandom_range(0, 3) == 0) ? TRIG : 8'($urandom);
      good = $urandom_range(0, 7) != 0;
      send_frame(b, good, 1'b1, $urandom_range(0, 30));
      idle(good ? $urandom_range(0, 20) : $urandom_range(4, 20));
    end
    drain();
    idle(50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
